planificador_bcd: RTL
=====================

Name: planificador_bcd

Overview:
- Schedules the single combinational `convertidor_bcd` (8-bit binary in, 12-bit packed BCD out) so that N_REQ requesters can share it.
- Typical requesters: the light-sensor capture path and the processor's display/report port.
- Arbitrates requests, registers the operand and the result, and returns a per-requester completion pulse with the BCD value.
- One conversion is in flight at a time.

Parameters:
- N_REQ, 2, number of requesters; legal range 2..4.
- ANCHO_DATO, 8, binary operand width; fixed to match the converter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  request per requester; level, held until granted.
- dato_in  input  N_REQ*8  operands; requester i occupies bits [8i+7:8i]; must be stable while req[i]=1.
- gnt  output  N_REQ  one-cycle grant pulse; operand captured.
- done  output  N_REQ  one-cycle completion pulse to the granted requester.
- decimal_out  output  12  {centenas, decenas, unidades}; valid when any done=1, held otherwise.
- busy  output  1  high while not in IDLE.

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE; gnt=0, done=0, busy=0, decimal_out=12'h000; arbitration pointer=0; operand register=0.
- FSM states: IDLE, CONVIERTE, ENTREGA.
- IDLE:
  - If |req at the clock edge, pick winner w, load operando<=dato_in[w] and id<=w.
  - gnt[w]=1 for the next cycle; go to CONVIERTE.
  - Otherwise stay in IDLE.
- CONVIERTE:
  - At the edge, decimal_out <= converter(operando); go to ENTREGA.
  - gnt returns to 0.
- ENTREGA:
  - done[id]=1 for exactly this cycle; go to IDLE at the next edge.
- Latency and throughput:
  - Request sampled at edge k → gnt high in cycle k+1, done high in cycle k+2.
  - Maximum rate is one conversion per 3 cycles.
- Requester contract:
  - May drop req the cycle gnt is seen.
  - A req still high when the FSM is back in IDLE is a new request; that requester is not starved under round-robin.
- Arbitration: round-robin (see Optional Feature).
  - Search starts at the pointer, wrapping modulo N_REQ.
  - After granting w, pointer <= (w+1) mod N_REQ; wrap from N_REQ-1 to 0.
- Datapath rules:
  - decimal_out changes only on the edge entering ENTREGA.
  - Output range is 12'h000..12'h255; bits [11:10] are always 0.
  - At most one gnt bit and one done bit are high in any cycle.
- Simultaneous events:
  - req changes during CONVIERTE/ENTREGA are ignored until IDLE.
  - A new request can be accepted on the same edge that leaves ENTREGA only if the FSM is already in IDLE; there is no bypass.
- Reset mid-operation:
  - Discards the in-flight conversion; no done is issued.
  - decimal_out returns to 12'h000 and the pointer to 0.
- gnt, done and busy are registered outputs (no combinational path from req).

Optional Feature:
- Macro: PLANIFICADOR_ROUND_ROBIN_EN.
- Defined: round-robin arbitration as above.
- Undefined:
  - Fixed priority; the lowest index with req=1 always wins.
  - The pointer register is not implemented.
  - All other timing is identical.

Decomposition:
- Shared package bcd_pkg:
  - ANCHO_DATO=8, ANCHO_BCD=12.
  - estado_planificador_t enum {IDLE, CONVIERTE, ENTREGA}.
  - Typedef bcd_t as a packed struct {centenas, decenas, unidades}, 4 bits each.
- Sub-module arbitro_rr:
  - Inputs: req, pointer, enable.
  - Outputs: one-hot winner and index.
  - Holds both the round-robin and fixed-priority variants under the macro.
- convertidor_bcd is instantiated unchanged as the datapath.

Test Plan:
- Reset then single request: req=01, dato_in[0]=8'd173 → gnt=01 one cycle later, then done=01 with decimal_out=12'h173; busy high for 2 cycles.
- Boundary values: operands 8'd0, 8'd9, 8'd99, 8'd100, 8'd255 on requester 1 → 12'h000, 12'h009, 12'h099, 12'h100, 12'h255.
- Contention with round-robin: req=11 held, dato0=8'd255, dato1=8'd7 → grants alternate 0,1,0,…; done[0]=1 with 12'h255, then done[1]=1 with 12'h007; 3-cycle spacing between consecutive gnt pulses.
- Fixed priority (macro undefined): req=11 held for 4 conversions → every gnt and done goes to requester 0; requester 1 is served only after req[0] drops.
- Reset mid-operation: assert reset in the CONVIERTE cycle → no done ever; next cycle outputs are all 0; a following request for 8'd42 completes with 12'h042.
- Late operand change: alter dato_in[0] from 8'd50 to 8'd60 during CONVIERTE → result is still 12'h050.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types for the BCD scheduler: FSM states, packed BCD digit struct and widths.
package bcd_pkg;
  localparam int ANCHO_DATO = 8;
  localparam int ANCHO_BCD  = 12;

  typedef enum logic [1:0] {IDLE, CONVIERTE, ENTREGA} estado_planificador_t;

  typedef struct packed {
    logic [3:0] centenas;
    logic [3:0] decenas;
    logic [3:0] unidades;
  } bcd_t;
endpackage

// File: rtl/arbitro_rr.sv
// Request arbiter: round-robin from pointer when PLANIFICADOR_ROUND_ROBIN_EN is defined,
// otherwise fixed priority (lowest index wins). Outputs are zero while enable is low.
module arbitro_rr #(
  parameter int N_REQ = 2,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    pointer,
  input  logic             enable,
  output logic [N_REQ-1:0] ganador,
  output logic [IW-1:0]    indice
);
  logic hallado;
  int   j;

`ifndef PLANIFICADOR_ROUND_ROBIN_EN
  logic unused_pointer;
  assign unused_pointer = ^pointer;
`endif

  always_comb begin
    ganador = '0;
    indice  = '0;
    hallado = 1'b0;
    j       = 0;
    if (enable) begin
      for (int k = 0; k < N_REQ; k++) begin
`ifdef PLANIFICADOR_ROUND_ROBIN_EN
        j = (int'(pointer) + k) % N_REQ;
`else
        j = k;
`endif
        if (!hallado && req[j]) begin
          hallado    = 1'b1;
          ganador[j] = 1'b1;
          indice     = IW'(j);
        end
      end
    end
  end
endmodule

// File: rtl/convertidor_bcd.sv
// Combinational 8-bit binary to 12-bit packed BCD converter.
module convertidor_bcd
  import bcd_pkg::*;
(
  input  logic [ANCHO_DATO-1:0] bin,
  output logic [ANCHO_BCD-1:0]  bcd
);
  logic [7:0] c, r, d, u;
  bcd_t       res;

  always_comb begin
    c = bin / 8'd100;
    r = bin % 8'd100;
    d = r / 8'd10;
    u = r % 8'd10;
    res.centenas = c[3:0];
    res.decenas  = d[3:0];
    res.unidades = u[3:0];
  end

  assign bcd = res;
endmodule

// File: rtl/planificador_bcd.sv
// Shares one convertidor_bcd among N_REQ requesters: IDLE -> CONVIERTE -> ENTREGA.
// Arbitration is round-robin with PLANIFICADOR_ROUND_ROBIN_EN defined, fixed priority otherwise.
module planificador_bcd
  import bcd_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ANCHO_DATO-1:0] dato_in,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [ANCHO_BCD-1:0]      decimal_out,
  output logic                      busy
);
  localparam int IW = $clog2(N_REQ);

  estado_planificador_t estado, estado_sig;
  logic [ANCHO_DATO-1:0] operando;
  logic [IW-1:0]         id, puntero, indice;
  logic [N_REQ-1:0]      ganador;
  logic [ANCHO_BCD-1:0]  bcd_res;
  logic                  en_arb;

  assign en_arb = (estado == IDLE);
  assign busy   = (estado != IDLE);

  arbitro_rr #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req     (req),
    .pointer (puntero),
    .enable  (en_arb),
    .ganador (ganador),
    .indice  (indice)
  );

  convertidor_bcd u_conv (
    .bin (operando),
    .bcd (bcd_res)
  );

  always_ff @(posedge clk) begin
    if (reset) estado <= IDLE;
    else       estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE:      if (|req) estado_sig = CONVIERTE;
      CONVIERTE: estado_sig = ENTREGA;
      ENTREGA:   estado_sig = IDLE;
      default:   estado_sig = IDLE;
    endcase
  end

`ifdef PLANIFICADOR_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset)
      puntero <= '0;
    else if (estado == IDLE && |req)
      puntero <= (indice == IW'(N_REQ-1)) ? '0 : indice + 1'b1;
  end
`else
  assign puntero = '0;
`endif

  // gnt/done are single-cycle pulses: cleared every edge unless re-set below.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt         <= '0;
      done        <= '0;
      decimal_out <= '0;
      operando    <= '0;
      id          <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (estado)
        IDLE: if (|req) begin
          operando <= dato_in[ANCHO_DATO*indice +: ANCHO_DATO];
          id       <= indice;
          gnt      <= ganador;
        end
        CONVIERTE: begin
          decimal_out <= bcd_res;
          done[id]    <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
